// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared constants, state encoding and width helper for the text display path
//
// Purpose: definitions shared by the text buffer, VGA timing and glyph blocks.
//   clog2      : ceiling log2, never less than 1 so single-entry ranges still get a bit
//   state_t    : clear/scroll engine states
//   DEF_*      : default screen geometry and blank fill character
package text_pkg;

    function automatic int clog2(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CLEAR  = 2'd1,
        SCROLL = 2'd2
    } state_t;

    localparam int DEF_COLS  = 80;
    localparam int DEF_ROWS  = 30;
    localparam int DEF_BLANK = 'h20;

endpackage

// File: rtl/text_buffer_ram.sv
// rtl/text_buffer_ram.sv - simple dual-port cell RAM, one write port, one read-first sync read port
//
// Purpose: backing store for the character buffer, shaped to map onto block RAM.
// Ports:
//   clk    in  clock
//   we     in  write enable
//   waddr  in  write address
//   wdata  in  write data
//   raddr  in  read address (registered read)
//   rdata  out read data, one cycle after raddr; old contents on a same-address write
module text_buffer_ram #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 2400,
    parameter int ADDR_W    = 12,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write and read in the same block so the read returns the pre-write value.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/text_buffer.sv
// rtl/text_buffer.sv - character/attribute buffer with hardware scroll and clear/scroll fill engine
//
// Purpose: cell store between the host text writer and the glyph renderer. Both ports use
// logical (col,row); the physical row is offset by a circular base so scrolling is a base
// bump plus refilling one row with BLANK.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   wr_valid/wr_ready host write handshake; wr_ready is high only while the engine is idle
//   wr_col/wr_row     host logical cell address; out-of-range writes are accepted and dropped
//   wr_data           host cell value
//   cmd_clear         pulse: fill screen with BLANK and reset base
//   cmd_scroll        pulse: scroll up one row, new bottom row filled with BLANK
//   busy              clear/scroll fill in progress
//   rd_col/rd_row     renderer logical cell address, sampled every cycle
//   rd_data           cell value two cycles after rd_col/rd_row; BLANK when out of range
module text_buffer
    import text_pkg::*;
#(
    parameter int COLS      = DEF_COLS,
    parameter int ROWS      = DEF_ROWS,
    parameter int DATA_W    = 8,
    parameter int BLANK     = DEF_BLANK,
    parameter     INIT_FILE = ""
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [clog2(COLS)-1:0]   wr_col,
    input  logic [clog2(ROWS)-1:0]   wr_row,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     cmd_clear,
    input  logic                     cmd_scroll,
    output logic                     busy,
    input  logic [clog2(COLS)-1:0]   rd_col,
    input  logic [clog2(ROWS)-1:0]   rd_row,
    output logic [DATA_W-1:0]        rd_data
);

    localparam int COL_W  = clog2(COLS);
    localparam int ROW_W  = clog2(ROWS);
    localparam int CELLS  = COLS * ROWS;
    localparam int ADDR_W = clog2(CELLS);

    localparam logic [DATA_W-1:0] BLANK_V    = DATA_W'(BLANK);
    localparam logic [COL_W:0]    COLS_V     = (COL_W + 1)'(COLS);
    localparam logic [ROW_W:0]    ROWS_V     = (ROW_W + 1)'(ROWS);
    localparam logic [ROW_W-1:0]  LAST_ROW   = ROW_W'(ROWS - 1);
    localparam logic [ADDR_W-1:0] COLS_A     = ADDR_W'(COLS);
    localparam logic [ADDR_W-1:0] LAST_CELL  = ADDR_W'(CELLS - 1);
    localparam logic [ADDR_W-1:0] LAST_COL_A = ADDR_W'(COLS - 1);

    function automatic logic in_range(input logic [COL_W-1:0] col, input logic [ROW_W-1:0] row);
        return ({1'b0, col} < COLS_V) && ({1'b0, row} < ROWS_V);
    endfunction

    // Logical to physical: row offset by base, wrapping once (row and base both < ROWS).
    function automatic logic [ADDR_W-1:0] map_addr(input logic [COL_W-1:0] col,
                                                   input logic [ROW_W-1:0] row,
                                                   input logic [ROW_W-1:0] b);
        logic [ROW_W:0] prow;
        prow = {1'b0, row} + {1'b0, b};
        if (prow >= ROWS_V) begin
            prow = prow - ROWS_V;
        end
        return ADDR_W'(prow) * COLS_A + ADDR_W'(col);
    endfunction

    // ------------------------------------------------------------------
    // Clear/scroll engine
    // ------------------------------------------------------------------
    state_t            state, state_nx;
    logic [ROW_W-1:0]  base, base_nx;
    logic [ADDR_W-1:0] fill_cnt, fill_cnt_nx;
    logic [ROW_W-1:0]  fill_row, fill_row_nx;
    logic              fill_we;
    logic [ADDR_W-1:0] fill_addr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            base     <= '0;
            fill_cnt <= '0;
            fill_row <= '0;
        end else begin
            state    <= state_nx;
            base     <= base_nx;
            fill_cnt <= fill_cnt_nx;
            fill_row <= fill_row_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        base_nx     = base;
        fill_cnt_nx = fill_cnt;
        fill_row_nx = fill_row;
        fill_we     = 1'b0;
        fill_addr   = '0;
        case (state)
            IDLE: begin
                if (cmd_clear) begin
                    state_nx    = CLEAR;
                    base_nx     = '0;
                    fill_cnt_nx = '0;
                end else if (cmd_scroll) begin
                    // The old top physical row becomes the new bottom logical row.
                    state_nx    = SCROLL;
                    fill_row_nx = base;
                    base_nx     = (base == LAST_ROW) ? '0 : base + 1'b1;
                    fill_cnt_nx = '0;
                end
            end
            CLEAR: begin
                fill_we   = 1'b1;
                fill_addr = fill_cnt;
                if (fill_cnt == LAST_CELL) begin
                    state_nx = IDLE;
                end else begin
                    fill_cnt_nx = fill_cnt + 1'b1;
                end
            end
            SCROLL: begin
                fill_we   = 1'b1;
                fill_addr = ADDR_W'(fill_row) * COLS_A + fill_cnt;
                if (fill_cnt == LAST_COL_A) begin
                    state_nx = IDLE;
                end else begin
                    fill_cnt_nx = fill_cnt + 1'b1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign wr_ready = (state == IDLE);
    assign busy     = (state != IDLE);

    // ------------------------------------------------------------------
    // Write mux: fill engine owns the port while busy, host otherwise.
    // Writes are suppressed while reset is asserted so an aborted fill stops cleanly.
    // ------------------------------------------------------------------
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;
    logic              host_we;

    always_comb begin
        host_we   = wr_valid && wr_ready && in_range(wr_col, wr_row);
        ram_waddr = map_addr(wr_col, wr_row, base);
        ram_wdata = wr_data;
        if (fill_we) begin
            ram_waddr = fill_addr;
            ram_wdata = BLANK_V;
        end
        ram_we = !rst && (fill_we || host_we);
    end

    // ------------------------------------------------------------------
    // Read pipe: stage 1 registers the physical address, stage 2 is the RAM read.
    // The valid bits keep rd_data at zero until real data has passed through.
    // ------------------------------------------------------------------
    logic [ADDR_W-1:0] rd_addr_q;
    logic              rd_oob_q1, rd_oob_q2;
    logic              rd_vld_q1, rd_vld_q2;
    logic [DATA_W-1:0] ram_rdata;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q <= '0;
            rd_oob_q1 <= 1'b0;
            rd_oob_q2 <= 1'b0;
            rd_vld_q1 <= 1'b0;
            rd_vld_q2 <= 1'b0;
        end else begin
            rd_addr_q <= in_range(rd_col, rd_row) ? map_addr(rd_col, rd_row, base) : '0;
            rd_oob_q1 <= !in_range(rd_col, rd_row);
            rd_oob_q2 <= rd_oob_q1;
            rd_vld_q1 <= 1'b1;
            rd_vld_q2 <= rd_vld_q1;
        end
    end

    always_comb begin
        rd_data = '0;
        if (rd_vld_q2) begin
            rd_data = rd_oob_q2 ? BLANK_V : ram_rdata;
        end
    end

    text_buffer_ram #(
        .DATA_W    (DATA_W),
        .DEPTH     (CELLS),
        .ADDR_W    (ADDR_W),
        .INIT_FILE (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (rd_addr_q),
        .rdata (ram_rdata)
    );

endmodule

// File: tb/tb_text_buffer.sv
// tb/tb_text_buffer.sv - self-checking bench for text_buffer with a logical-screen model
module tb_text_buffer;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic       wr_ready;
    logic [6:0] wr_col;
    logic [4:0] wr_row;
    logic [7:0] wr_data;
    logic       cmd_clear;
    logic       cmd_scroll;
    logic       busy;
    logic [6:0] rd_col;
    logic [4:0] rd_row;
    logic [7:0] rd_data;

    int checks = 0;
    int passes = 0;
    int model [30][80];

    typedef struct {
        bit is_wr;
        int col;
        int row;
        int data;
        int exp;
    } vec_t;

    vec_t vecs [16];

    always #5 clk = ~clk;

    text_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .wr_valid   (wr_valid),
        .wr_ready   (wr_ready),
        .wr_col     (wr_col),
        .wr_row     (wr_row),
        .wr_data    (wr_data),
        .cmd_clear  (cmd_clear),
        .cmd_scroll (cmd_scroll),
        .busy       (busy),
        .rd_col     (rd_col),
        .rd_row     (rd_row),
        .rd_data    (rd_data)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got == exp) passes++;
        else $display("FAIL %s: got 'h%0h, expected 'h%0h", name, got, exp);
    endtask

    task automatic model_fill();
        for (int r = 0; r < 30; r++)
            for (int c = 0; c < 80; c++)
                model[r][c] = 'h20;
    endtask

    task automatic model_scroll();
        for (int r = 0; r < 29; r++)
            for (int c = 0; c < 80; c++)
                model[r][c] = model[r + 1][c];
        for (int c = 0; c < 80; c++) model[29][c] = 'h20;
    endtask

    task automatic do_write(input int c, input int r, input int d);
        wr_col = 7'(c); wr_row = 5'(r); wr_data = 8'(d); wr_valid = 1'b1;
        check("wr_ready_idle", int'(wr_ready), 1);
        tick();
        wr_valid = 1'b0;
        if (c < 80 && r < 30) model[r][c] = d;
    endtask

    task automatic do_read(input int c, input int r, output int d);
        rd_col = 7'(c); rd_row = 5'(r);
        tick();
        tick();
        d = int'(rd_data);
    endtask

    // Present a new address every cycle; data for address k-1 arrives after tick k.
    task automatic scan(input string name);
        int bad;
        bad = 0;
        for (int k = 0; k <= 2400; k++) begin
            if (k < 2400) begin
                rd_col = 7'(k % 80);
                rd_row = 5'(k / 80);
            end
            tick();
            if (k >= 1 && int'(rd_data) != model[(k - 1) / 80][(k - 1) % 80]) bad++;
        end
        check(name, bad, 0);
    endtask

    // Issue a command, then count busy cycles (bounded). Optionally pulse cmd_scroll or rst
    // at a given busy-cycle index.
    task automatic command(input bit clr, input bit scr, input int scroll_at, input int rst_at,
                           output int n, output int rdy_err);
        cmd_clear = clr; cmd_scroll = scr;
        tick();
        cmd_clear = 1'b0; cmd_scroll = 1'b0; wr_valid = 1'b0;
        check("busy_after_cmd", int'(busy), 1);
        n = 0; rdy_err = 0;
        while (busy && n < 5000) begin
            if (n == scroll_at) cmd_scroll = 1'b1;
            if (n == rst_at) rst = 1'b1;
            if (wr_ready) rdy_err++;
            n++;
            tick();
            cmd_scroll = 1'b0;
            rst = 1'b0;
        end
    endtask

    initial begin
        int n, rerr, d;

        rst = 1'b1; wr_valid = 1'b0; wr_col = '0; wr_row = '0; wr_data = '0;
        cmd_clear = 1'b0; cmd_scroll = 1'b0; rd_col = '0; rd_row = '0;
        model_fill();
        repeat (3) tick();
        check("rst_busy", int'(busy), 0);
        check("rst_wr_ready", int'(wr_ready), 1);
        check("rst_rd_data", int'(rd_data), 0);
        check("rst_base", int'(dut.base), 0);
        rst = 1'b0;
        tick();

        // Clear
        command(1'b1, 1'b0, -1, -1, n, rerr);
        check("clear_busy_cycles", n, 2400);
        check("clear_wr_ready_low", rerr, 0);
        check("clear_busy_end", int'(busy), 0);
        model_fill();
        scan("clear_all_blank");

        // Table of writes and reads, including out-of-range columns/rows
        vecs[0]  = '{1, 3, 2, 'h41, 0};
        vecs[1]  = '{0, 3, 2, 0, 'h41};
        vecs[2]  = '{0, 4, 2, 0, 'h20};
        vecs[3]  = '{1, 80, 2, 'h55, 0};
        vecs[4]  = '{0, 79, 2, 0, 'h20};
        vecs[5]  = '{0, 0, 3, 0, 'h20};
        vecs[6]  = '{0, 80, 2, 0, 'h20};
        vecs[7]  = '{0, 0, 30, 0, 'h20};
        vecs[8]  = '{1, 0, 0, 'h7e, 0};
        vecs[9]  = '{0, 0, 0, 0, 'h7e};
        vecs[10] = '{1, 79, 29, 'h33, 0};
        vecs[11] = '{0, 79, 29, 0, 'h33};
        vecs[12] = '{0, 0, 31, 0, 'h20};
        vecs[13] = '{1, 0, 3, 'h5a, 0};
        vecs[14] = '{0, 80, 2, 0, 'h20};
        vecs[15] = '{0, 0, 3, 0, 'h5a};
        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_wr) begin
                do_write(vecs[i].col, vecs[i].row, vecs[i].data);
            end else begin
                do_read(vecs[i].col, vecs[i].row, d);
                check($sformatf("vec%0d_read", i), d, vecs[i].exp);
            end
        end

        // Exact two-cycle read latency
        rd_col = 7'd4; rd_row = 5'd2;
        tick(); tick();
        check("lat_prev", int'(rd_data), 'h20);
        rd_col = 7'd3; rd_row = 5'd2;
        tick();
        check("lat_1cyc_old", int'(rd_data), 'h20);
        tick();
        check("lat_2cyc_new", int'(rd_data), 'h41);

        // Same-address read and write: old value first, new value next cycle
        do_write(3, 2, 'h99);
        check("rw_same_old", int'(rd_data), 'h41);
        tick();
        check("rw_same_new", int'(rd_data), 'h99);

        // 30 scrolls return base to 0; bottom-right cell usable at every step
        for (int k = 0; k < 30; k++) begin
            command(1'b0, 1'b1, -1, -1, n, rerr);
            check($sformatf("scroll%0d_cycles", k), n, 80);
            model_scroll();
            do_write(79, 29, 'h80 + k);
            do_read(79, 29, d);
            check($sformatf("scroll%0d_br", k), d, 'h80 + k);
        end
        check("scroll30_base", int'(dut.base), 0);
        scan("scroll30_screen");

        // Single scroll moves row 1 to row 0, bottom row blank
        do_write(0, 1, 'h41);
        command(1'b0, 1'b1, -1, -1, n, rerr);
        check("scroll_busy_cycles", n, 80);
        check("scroll_wr_ready_low", rerr, 0);
        model_scroll();
        do_read(0, 0, d);
        check("scroll_row0", d, 'h41);
        scan("scroll_screen");

        // Write and scroll in the same idle cycle: write lands before the scroll
        wr_col = 7'd5; wr_row = 5'd5; wr_data = 8'h66; wr_valid = 1'b1;
        command(1'b0, 1'b1, -1, -1, n, rerr);
        model[5][5] = 'h66;
        model_scroll();
        check("wr_scroll_cycles", n, 80);
        do_read(5, 4, d);
        check("wr_scroll_cell", d, 'h66);

        // Clear wins over scroll; scroll while busy is dropped
        command(1'b1, 1'b1, 10, -1, n, rerr);
        check("clr_scr_cycles", n, 2400);
        repeat (3) tick();
        check("scroll_ignored", int'(busy), 0);
        check("clr_scr_base", int'(dut.base), 0);
        model_fill();
        do_write(80, 3, 'h55);
        do_write(4, 30, 'h56);
        scan("oob_write_no_change");

        // Reset in the middle of a clear
        do_write(19, 1, 'h11);
        do_write(20, 1, 'h12);
        do_write(21, 1, 'h13);
        do_write(79, 29, 'h14);
        command(1'b1, 1'b0, -1, 100, n, rerr);
        check("rst_mid_cycles", n, 101);
        check("rst_mid_busy", int'(busy), 0);
        check("rst_mid_base", int'(dut.base), 0);
        check("rst_mid_rd_data", int'(rd_data), 0);
        check("rst_mid_wr_ready", int'(wr_ready), 1);
        for (int i = 0; i < 100; i++) model[i / 80][i % 80] = 'h20;
        do_read(20, 1, d);
        check("rst_mid_keep100", d, 'h12);
        do_read(19, 1, d);
        check("rst_mid_cleared99", d, 'h20);
        scan("rst_mid_screen");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
